// File: rtl/gnrl_fifo.sv
// General-purpose valid/ready FIFO with arbitrary (non power-of-two) depth.
// Optional occupancy output port `cnt` when macro GNRL_FIFO_CNT_EN is defined.
module gnrl_fifo #(
   parameter int DW        = 32,
   parameter int DP        = 8,
   parameter bit CUT_READY = 1'b0,
   parameter bit MSKO      = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_vld,
   output logic                     i_rdy,
   input  logic [DW-1:0]            i_dat,
   output logic                     o_vld,
   input  logic                     o_rdy,
   output logic [DW-1:0]            o_dat
`ifdef GNRL_FIFO_CNT_EN
   ,
   output logic [$clog2(DP+1)-1:0]  cnt
`endif
);

   localparam int AW = (DP > 1) ? $clog2(DP) : 1;
   localparam int CW = $clog2(DP + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DP);
   localparam logic [AW-1:0] LAST_PTR = AW'(DP - 1);

   logic [DW-1:0] mem [DP];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] occ;
   logic [CW-1:0] occ_nxt;
   logic          vld_q;
   logic          not_full;
   logic          push;
   logic          pop;

   assign not_full = (occ < FULL_CNT);

   // With CUT_READY the ready depends on registered occupancy only, breaking the o_rdy -> i_rdy path.
   generate
      if (CUT_READY) begin : g_cut_ready
         assign i_rdy = not_full;
      end else begin : g_pass_ready
         assign i_rdy = not_full | o_rdy;
      end
   endgenerate

   assign push = i_vld & i_rdy;
   assign pop  = vld_q & o_rdy;

   always_comb begin
      occ_nxt = occ;
      case ({push, pop})
         2'b10:   occ_nxt = occ + CW'(1);
         2'b01:   occ_nxt = occ - CW'(1);
         default: occ_nxt = occ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         occ   <= '0;
         vld_q <= 1'b0;
      end else begin
         if (push) begin
            wptr <= (wptr == LAST_PTR) ? '0 : wptr + AW'(1);
         end
         if (pop) begin
            rptr <= (rptr == LAST_PTR) ? '0 : rptr + AW'(1);
         end
         occ   <= occ_nxt;
         vld_q <= (occ_nxt != '0);
      end
   end

   // Payload storage carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= i_dat;
      end
   end

   assign o_vld = vld_q;

   generate
      if (MSKO) begin : g_mask_out
         assign o_dat = vld_q ? mem[rptr] : '0;
      end else begin : g_raw_out
         assign o_dat = mem[rptr];
      end
   endgenerate

`ifdef GNRL_FIFO_CNT_EN
   assign cnt = occ;
`endif

endmodule

// File: tb/tb_gnrl_fifo.sv
// Bench for gnrl_fifo: five configurations driven in lock-step, each checked against a queue model.
// Instances: 0 DP4, 1 DP4 CUT_READY, 2 DP3, 3 DP4 MSKO, 4 DP1.
module tb_gnrl_fifo;

   localparam int N = 5;

   logic        clk;
   logic        rst_n;
   logic        i_vld [N];
   logic        i_rdy [N];
   logic [31:0] i_dat [N];
   logic        o_vld [N];
   logic        o_rdy [N];
   logic [31:0] o_dat [N];
`ifdef GNRL_FIFO_CNT_EN
   logic [2:0]  cnt0;
   logic [2:0]  cnt1;
   logic [1:0]  cnt2;
   logic [2:0]  cnt3;
   logic [0:0]  cnt4;
`endif

   int dp_t [N];
   bit cr_t [N];
   bit mk_t [N];

   logic [31:0] q [N][$];

   int n_chk;
   int n_fail;

   gnrl_fifo #(.DW(32), .DP(4), .CUT_READY(1'b0), .MSKO(1'b0)) u_f0 (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld[0]), .i_rdy(i_rdy[0]), .i_dat(i_dat[0]),
      .o_vld(o_vld[0]), .o_rdy(o_rdy[0]), .o_dat(o_dat[0])
`ifdef GNRL_FIFO_CNT_EN
      , .cnt(cnt0)
`endif
   );

   gnrl_fifo #(.DW(32), .DP(4), .CUT_READY(1'b1), .MSKO(1'b0)) u_f1 (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld[1]), .i_rdy(i_rdy[1]), .i_dat(i_dat[1]),
      .o_vld(o_vld[1]), .o_rdy(o_rdy[1]), .o_dat(o_dat[1])
`ifdef GNRL_FIFO_CNT_EN
      , .cnt(cnt1)
`endif
   );

   gnrl_fifo #(.DW(32), .DP(3), .CUT_READY(1'b0), .MSKO(1'b0)) u_f2 (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld[2]), .i_rdy(i_rdy[2]), .i_dat(i_dat[2]),
      .o_vld(o_vld[2]), .o_rdy(o_rdy[2]), .o_dat(o_dat[2])
`ifdef GNRL_FIFO_CNT_EN
      , .cnt(cnt2)
`endif
   );

   gnrl_fifo #(.DW(32), .DP(4), .CUT_READY(1'b0), .MSKO(1'b1)) u_f3 (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld[3]), .i_rdy(i_rdy[3]), .i_dat(i_dat[3]),
      .o_vld(o_vld[3]), .o_rdy(o_rdy[3]), .o_dat(o_dat[3])
`ifdef GNRL_FIFO_CNT_EN
      , .cnt(cnt3)
`endif
   );

   gnrl_fifo #(.DW(32), .DP(1), .CUT_READY(1'b0), .MSKO(1'b0)) u_f4 (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld[4]), .i_rdy(i_rdy[4]), .i_dat(i_dat[4]),
      .o_vld(o_vld[4]), .o_rdy(o_rdy[4]), .o_dat(o_dat[4])
`ifdef GNRL_FIFO_CNT_EN
      , .cnt(cnt4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

`ifdef GNRL_FIFO_CNT_EN
   function automatic int cnt_of(input int k);
      case (k)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         2:       return int'(cnt2);
         3:       return int'(cnt3);
         default: return int'(cnt4);
      endcase
   endfunction
`endif

   task automatic set_all(input logic v, input logic [31:0] d, input logic r);
      for (int k = 0; k < N; k++) begin
         i_vld[k] = v;
         i_dat[k] = d;
         o_rdy[k] = r;
      end
   endtask

   // One clock: compare outputs to the model on the falling edge, then apply the handshake rules.
   task automatic step();
      bit          do_push [N];
      bit          do_pop  [N];
      logic [31:0] d       [N];
      int          sz;
      bit          exp_vld;
      bit          exp_rdy;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         sz      = q[k].size();
         exp_vld = (sz > 0);
         exp_rdy = (sz < dp_t[k]) || (!cr_t[k] && o_rdy[k]);
         check($sformatf("o_vld[%0d]", k), 64'(o_vld[k]), 64'(exp_vld));
         check($sformatf("i_rdy[%0d]", k), 64'(i_rdy[k]), 64'(exp_rdy));
         if (exp_vld) begin
            check($sformatf("o_dat[%0d]", k), 64'(o_dat[k]), 64'(q[k][0]));
         end else if (mk_t[k]) begin
            check($sformatf("o_dat_mask[%0d]", k), 64'(o_dat[k]), 64'd0);
         end
`ifdef GNRL_FIFO_CNT_EN
         check($sformatf("cnt[%0d]", k), 64'(cnt_of(k)), 64'(sz));
`endif
         do_push[k] = i_vld[k] && exp_rdy;
         do_pop[k]  = exp_vld && o_rdy[k];
         d[k]       = i_dat[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (do_pop[k]) void'(q[k].pop_front());
         if (do_push[k]) q[k].push_back(d[k]);
      end
   endtask

   initial begin
      int pv;
      int pr;
      n_chk  = 0;
      n_fail = 0;
      dp_t = '{4, 4, 3, 4, 1};
      cr_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      mk_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      set_all(1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;

      // Reset state
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst_o_vld[%0d]", k), 64'(o_vld[k]), 64'd0);
         check($sformatf("rst_i_rdy[%0d]", k), 64'(i_rdy[k]), 64'd1);
      end
      check("rst_o_dat_mask", 64'(o_dat[3]), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill with A,B,C,D while the consumer stalls
      for (int i = 0; i < 4; i++) begin
         set_all(1'b1, 32'hA0 + 32'(i), 1'b0);
         step();
      end
      set_all(1'b0, 32'h0, 1'b0);
      #1;
      check("full_i_rdy0", 64'(i_rdy[0]), 64'd0);
      check("full_i_rdy1", 64'(i_rdy[1]), 64'd0);
      check("full_head0", 64'(o_dat[0]), 64'hA0);
`ifdef GNRL_FIFO_CNT_EN
      check("full_cnt0", 64'(cnt0), 64'd4);
`endif

      // Push E into a full FIFO while popping
      set_all(1'b1, 32'hE0, 1'b1);
      #1;
      check("fullpop_i_rdy0", 64'(i_rdy[0]), 64'd1);
      check("fullpop_i_rdy1", 64'(i_rdy[1]), 64'd0);
      step();
      set_all(1'b0, 32'h0, 1'b0);
      #1;
      check("after_pop_head0", 64'(o_dat[0]), 64'hA1);
      check("after_pop_head1", 64'(o_dat[1]), 64'hA1);
`ifdef GNRL_FIFO_CNT_EN
      check("after_pop_cnt0", 64'(cnt0), 64'd4);
      check("after_pop_cnt1", 64'(cnt1), 64'd3);
`endif

      // Drain everything
      set_all(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) step();

      // Masked output: zero before the edge, payload after
      set_all(1'b1, 32'hDEADBEEF, 1'b0);
      #1;
      check("mask_before", 64'(o_dat[3]), 64'd0);
      check("mask_vld_before", 64'(o_vld[3]), 64'd0);
      step();
      check("mask_after_vld", 64'(o_vld[3]), 64'd1);
      check("mask_after_dat", 64'(o_dat[3]), 64'hDEADBEEF);
      set_all(1'b1, 32'h1234, 1'b0);
      step();
      set_all(1'b0, 32'h0, 1'b0);

      // Asynchronous reset between edges discards held entries
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("arst_o_vld[%0d]", k), 64'(o_vld[k]), 64'd0);
         check($sformatf("arst_i_rdy[%0d]", k), 64'(i_rdy[k]), 64'd1);
         q[k].delete();
      end
`ifdef GNRL_FIFO_CNT_EN
      check("arst_cnt0", 64'(cnt0), 64'd0);
`endif
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_all(1'b1, 32'h5A5A5A5A, 1'b0);
      step();
      set_all(1'b0, 32'h0, 1'b1);
      #1;
      check("post_rst_vld", 64'(o_vld[0]), 64'd1);
      check("post_rst_dat", 64'(o_dat[0]), 64'h5A5A5A5A);
      step();

      // Randomized traffic with changing producer/consumer pressure
      pv = 50;
      pr = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) begin
            pv = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
         end
         for (int k = 0; k < N; k++) begin
            i_vld[k] = ($urandom_range(0, 99) < pv);
            i_dat[k] = $urandom;
            o_rdy[k] = ($urandom_range(0, 99) < pr);
         end
         step();
      end

      set_all(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) step();
      for (int k = 0; k < N; k++) begin
         check($sformatf("end_empty[%0d]", k), 64'(o_vld[k]), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gnrl_fifo.md
GNRL_FIFO -- requirements
Module: gnrl_fifo

Interface
REQ-001 The block SHALL expose parameter DW, default 32, payload width in bits (1..1024).
REQ-002 The block SHALL expose parameter DP, default 8, storage depth in entries (1..64, power of two not required).
REQ-003 The block SHALL expose parameter CUT_READY, default 0: 1 makes i_rdy a function of registered state only.
REQ-004 The block SHALL expose parameter MSKO, default 0: 1 forces o_dat to zero whenever o_vld is low.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock, the only clock.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port i_vld, input, 1, write request.
REQ-008 The block SHALL have port i_rdy, output, 1, FIFO can accept a write this cycle.
REQ-009 The block SHALL have port i_dat, input, DW, write payload.
REQ-010 The block SHALL have port o_vld, output, 1, FIFO holds at least one entry.
REQ-011 The block SHALL have port o_rdy, input, 1, consumer accepts head entry.
REQ-012 The block SHALL have port o_dat, output, DW, head entry payload.

Function
REQ-013 push = i_vld & i_rdy; pop = o_vld & o_rdy; both take effect on the rising clk edge.
REQ-014 Write and read pointers SHALL run 0..DP-1 and wrap to 0 after DP-1, with no power-of-two restriction.
REQ-015 Occupancy SHALL be held in a $clog2(DP+1)-bit counter: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-016 o_vld SHALL be 1 exactly when occupancy > 0, driven from a register with no combinational path from i_vld.
REQ-017 With CUT_READY=0, i_rdy = (occupancy < DP) | o_rdy, so a push into a full FIFO is legal when a pop occurs in the same cycle.
REQ-018 With CUT_READY=1, i_rdy = (occupancy < DP), with no combinational path from o_rdy.
REQ-019 Latency SHALL be one cycle: data pushed at edge N is visible on o_dat and o_vld after edge N and before edge N+1; there is no same-cycle bypass.
REQ-020 o_dat SHALL equal the entry at the read pointer; with MSKO=1 it SHALL be {DW{1'b0}} while o_vld=0.
REQ-021 Entries SHALL leave in push order; no entry is lost or duplicated.
REQ-022 When empty, pop is impossible; a simultaneous i_vld and o_rdy SHALL perform the push only.
REQ-023 When full with CUT_READY=1, i_vld SHALL be ignored even if o_rdy=1; occupancy drops to DP-1.
REQ-024 i_vld with i_rdy=0 SHALL leave storage, pointers and occupancy unchanged.
REQ-025 DP=1 SHALL behave as a single-entry valid/ready register with the same rules.

Reset
REQ-026 On rst_n low, pointers, occupancy and o_vld SHALL clear to 0 immediately, without waiting for clk.
REQ-027 Storage entries SHALL NOT be reset; o_dat is undefined after reset when MSKO=0 and 0 when MSKO=1.
REQ-028 During reset, i_rdy SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first push after release lands in entry 0.

Configuration
REQ-030 With macro GNRL_FIFO_CNT_EN defined, the block SHALL add output port cnt, width $clog2(DP+1), equal to the registered occupancy and reset to 0.
REQ-031 Without GNRL_FIFO_CNT_EN, port cnt SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 DP=4, CUT_READY=0, o_rdy=0: push A,B,C,D on consecutive cycles -> i_rdy=0 after the 4th edge, o_dat=A, and cnt=4 when enabled.
REQ-033 Full DP=4, CUT_READY=0: i_vld=1, i_dat=E, o_rdy=1 for one cycle -> A popped, E accepted, occupancy stays 4, and the next o_dat=B.
REQ-034 Same condition with CUT_READY=1 -> i_rdy=0, E not accepted, occupancy 3.
REQ-035 DP=3: stream 10 words with random o_rdy stalls -> output order 0..9 with no gaps across pointer wraps.
REQ-036 DP=4, MSKO=1: empty FIFO, push 0xDEADBEEF -> o_dat=0 before the edge and 0xDEADBEEF with o_vld=1 one cycle later.
REQ-037 Two entries held; pulse rst_n low between edges -> o_vld=0 and cnt=0 immediately; after release, push X then pop returns X.
